fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_npc.sv | 38 +++
 rtl/fetch_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage: redirect codes, the
// bubble instruction word and the default reset PC.
package fetch_stage_pkg;

   localparam logic [1:0] BR_SEQ    = 2'b00;
   localparam logic [1:0] BR_BRANCH = 2'b01;
   localparam logic [1:0] BR_JUMP   = 2'b10;
   localparam logic [1:0] BR_JR     = 2'b11;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC selection: sequential PC+4 or the redirect target
// decoded from the ID instruction's branch code.
module npc_calc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] if_id_pc4,
   input  logic [1:0]  branch,
   input  logic [15:0] imm16,
   input  logic [25:0] jtarget,
   input  logic [31:0] rs_data,
   input  logic        redirect,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   logic [31:0] br_offset;
   logic [31:0] target;

   // Sums wrap naturally at 32 bits, so 0xFFFF_FFFC + 4 lands on 0.
   assign pc_plus4  = pc + 32'd4;
   assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      target = pc_plus4;
      case (branch)
         BR_SEQ:    target = pc_plus4;
         BR_BRANCH: target = if_id_pc4 + br_offset;
         BR_JUMP:   target = {if_id_pc4[31:28], jtarget, 2'b00};
         BR_JR:     target = {rs_data[31:2], 2'b00};
         default:   target = pc_plus4;
      endcase
   end

   assign next_pc = redirect ? target : pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC and IF/ID pipeline registers with hold and
// flush-on-redirect control; target arithmetic lives in npc_calc.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  Branch,
   input  logic [15:0] imm16,
   input  logic [25:0] jtarget,
   input  logic [31:0] rs_data,
   input  logic        stall,
   input  logic        MIO_ready,
   input  logic [31:0] inst_in,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [5:0]  OPcode,
   output logic [5:0]  Fun
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        hold, redirect;
   logic [31:0] pc_plus4, next_pc;

   assign hold     = stall | ~MIO_ready;
   // A bubble in ID carries no real branch, so its code is ignored.
   assign redirect = (Branch != BR_SEQ) & valid_q;

   npc_calc u_npc_calc (
      .pc        (pc_q),
      .if_id_pc4 (pc4_q),
      .branch    (Branch),
      .imm16     (imm16),
      .jtarget   (jtarget),
      .rs_data   (rs_data),
      .redirect  (redirect),
      .pc_plus4  (pc_plus4),
      .next_pc   (next_pc)
   );

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (!hold) begin
         pc_d = next_pc;
         if (redirect) begin
            // Flush: no delay slot, the fetched word is squashed.
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
         end else begin
            inst_d  = inst_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) begin
         pc_q    <= {RESET_PC[31:2], 2'b00};
         inst_q  <= NOP_WORD;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign pc_out      = pc_q;
   assign if_id_inst  = inst_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign OPcode      = inst_q[31:26];
   assign Fun         = inst_q[5:0];

endmodule
